instruction_fetch_buffer: RTL and testbench

- Sits directly downstream of the PC register stage and upstream of decode.
- Takes the registered PC each cycle and issues it as an instruction-memory request.
- Matches in-order memory responses to their PCs and buffers PC/instruction pairs in a small FIFO.
- Presents pairs to decode over a valid/ready handshake, and stalls the PC stage when it cannot accept.

---
 rtl/instruction_fetch_buffer.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: issues the registered PC as an instruction-memory
// request, pairs in-order responses with their PCs, and buffers the pairs in
// a small FIFO toward decode. Outstanding fetches plus buffered entries are
// capped at DEPTH, so the FIFO can never overflow.
// Optional: define IFB_MISALIGN_CHECK_EN to turn misaligned PCs into local
// NOP entries flagged on ID_MISALIGNED instead of sending them to memory.
module instruction_fetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC_IN,
  input  logic        PC_VALID,
  output logic        PC_READY,
  input  logic        FLUSH,
  output logic        IMEM_REQ_VALID,
  output logic [31:0] IMEM_REQ_ADDR,
  input  logic        IMEM_REQ_READY,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RSP_DATA,
  output logic        ID_VALID,
  input  logic        ID_READY,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_INSTRUCTION,
  output logic        ID_MISALIGNED
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   pend_pc [DEPTH];
  logic [AW-1:0] pend_wr, pend_rd;

  logic [CW-1:0] inflight, discard, inflight_next;
  logic [CW:0]   occupancy;
  logic          credit, accept, issue, rsp_live, rsp_push, push, pop;
  logic          misaligned, mis_hold, mis_write;
  logic [31:0]   push_pc, push_ins;

  // A held misaligned entry occupies a slot exactly like an in-flight fetch.
  assign occupancy = {1'b0, count} + {1'b0, inflight} + {{CW{1'b0}}, mis_hold};
  assign credit    = occupancy < (CW+1)'(DEPTH);
  assign accept    = PC_VALID & credit & ~FLUSH & ~mis_hold;

  assign IMEM_REQ_VALID = accept & ~misaligned;
  assign IMEM_REQ_ADDR  = PC_IN;
  assign issue          = IMEM_REQ_VALID & IMEM_REQ_READY;
  assign PC_READY       = issue | (accept & misaligned);

  // Responses with nothing outstanding are unsolicited and ignored outright.
  assign rsp_live = IMEM_RSP_VALID & (inflight != '0);
  assign rsp_push = rsp_live & (discard == '0) & ~FLUSH;
  assign push     = rsp_push | mis_write;

  assign ID_VALID       = count != '0;
  assign pop            = ID_VALID & ID_READY;
  assign ID_PC          = ID_VALID ? fifo_pc[rd_ptr]  : '0;
  assign ID_INSTRUCTION = ID_VALID ? fifo_ins[rd_ptr] : NOP;

  // Next in-flight count: issue adds one, any live response removes one.
  always_comb begin
    inflight_next = inflight;
    if (issue && !rsp_live)
      inflight_next = inflight + CW'(1);
    else if (!issue && rsp_live)
      inflight_next = inflight - CW'(1);
  end

`ifdef IFB_MISALIGN_CHECK_EN
  logic [31:0] mis_pc;
  logic        fifo_mis [DEPTH];

  assign misaligned    = PC_IN[1:0] != 2'b00;
  // Written only once every earlier fetch has returned, preserving order.
  assign mis_write     = mis_hold & (inflight == '0) & ~FLUSH;
  assign push_pc       = mis_write ? mis_pc : pend_pc[pend_rd];
  assign push_ins      = mis_write ? NOP : IMEM_RSP_DATA;
  assign ID_MISALIGNED = ID_VALID & fifo_mis[rd_ptr];

  // Hold an accepted misaligned PC until it can be queued behind older fetches.
  always_ff @(posedge CLK) begin
    if (!RST_N || FLUSH) begin
      mis_hold <= 1'b0;
      mis_pc   <= '0;
    end else if (mis_write) begin
      mis_hold <= 1'b0;
    end else if (accept && misaligned) begin
      mis_hold <= 1'b1;
      mis_pc   <= PC_IN;
    end
  end

  // Misaligned flag storage alongside each FIFO entry.
  always_ff @(posedge CLK) begin
    if (push) fifo_mis[wr_ptr] <= mis_write;
  end
`else
  assign misaligned    = 1'b0;
  assign mis_hold      = 1'b0;
  assign mis_write     = 1'b0;
  assign push_pc       = pend_pc[pend_rd];
  assign push_ins      = IMEM_RSP_DATA;
  assign ID_MISALIGNED = 1'b0;
`endif

  // FIFO, pending-PC queue and fetch accounting; FLUSH drops everything
  // buffered and arms discard with whatever is still outstanding.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend_wr  <= '0;
      pend_rd  <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (FLUSH) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend_wr  <= '0;
      pend_rd  <= '0;
      inflight <= inflight_next;
      discard  <= inflight_next;
    end else begin
      inflight <= inflight_next;
      if (rsp_live && discard != '0)
        discard <= discard - CW'(1);
      if (issue) begin
        pend_pc[pend_wr] <= PC_IN;
        pend_wr          <= pend_wr + AW'(1);
      end
      if (rsp_push)
        pend_rd <= pend_rd + AW'(1);
      if (push) begin
        fifo_pc[wr_ptr]  <= push_pc;
        fifo_ins[wr_ptr] <= push_ins;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer: a behavioural in-order
// memory with configurable latency plus a scoreboard of expected ID pairs.
module tb_instruction_fetch_buffer;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int unsigned DEPTH = 4;

  logic        CLK, RST_N;
  logic [31:0] PC_IN;
  logic        PC_VALID, PC_READY, FLUSH;
  logic        IMEM_REQ_VALID, IMEM_REQ_READY;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_RSP_VALID;
  logic [31:0] IMEM_RSP_DATA;
  logic        ID_VALID, ID_READY, ID_MISALIGNED;
  logic [31:0] ID_PC, ID_INSTRUCTION;

  instruction_fetch_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC_IN(PC_IN), .PC_VALID(PC_VALID),
    .PC_READY(PC_READY), .FLUSH(FLUSH), .IMEM_REQ_VALID(IMEM_REQ_VALID),
    .IMEM_REQ_ADDR(IMEM_REQ_ADDR), .IMEM_REQ_READY(IMEM_REQ_READY),
    .IMEM_RSP_VALID(IMEM_RSP_VALID), .IMEM_RSP_DATA(IMEM_RSP_DATA),
    .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_PC(ID_PC),
    .ID_INSTRUCTION(ID_INSTRUCTION), .ID_MISALIGNED(ID_MISALIGNED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] data; int unsigned due; bit live; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic mis; } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, issues = 0, ids_seen = 0, occ_prev = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  int          first_issue = -1, first_valid = -1;
  logic [31:0] next_data = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        s_pc_ready, s_id_valid, s_id_mis;
  logic [31:0] s_id_pc, s_id_ins;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock cycle: inputs already set at the negedge by the caller.
  task automatic cycle();
    exp_t        e;
    int unsigned live, occ;
    logic        exp_ready;
    if (RST_N && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      IMEM_RSP_VALID = 1'b1;
      IMEM_RSP_DATA  = mem_q[0].data;
    end else begin
      IMEM_RSP_VALID = 1'b0;
      IMEM_RSP_DATA  = '0;
    end
    #4;
    s_pc_ready = PC_READY;
    s_id_valid = ID_VALID;
    s_id_pc    = ID_PC;
    s_id_ins   = ID_INSTRUCTION;
    s_id_mis   = ID_MISALIGNED;
    if (!RST_N) begin
      mem_q.delete();
      exp_q.delete();
      occ_prev = 0;
    end else begin
`ifndef IFB_MISALIGN_CHECK_EN
      exp_ready = PC_VALID && !FLUSH && IMEM_REQ_READY && (occ_prev < DEPTH);
      check1("pc_ready_vs_credit", PC_READY, exp_ready);
`endif
      if (IMEM_RSP_VALID) void'(mem_q.pop_front());
      if (ID_VALID && ID_READY) begin
        ids_seen++;
        if (exp_q.size() == 0) begin
          check1("unexpected_output", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", ID_PC, e.pc);
          check("id_instruction", ID_INSTRUCTION, e.ins);
          check1("id_misaligned", ID_MISALIGNED, e.mis);
        end
      end else if (!ID_VALID) begin
        check("idle_nop", ID_INSTRUCTION, NOP);
        check1("idle_misaligned", ID_MISALIGNED, 1'b0);
      end
      if (ID_VALID && first_valid < 0) first_valid = int'(cyc);
      if (FLUSH) begin
        check1("flush_no_issue", PC_READY, 1'b0);
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
      end else if (PC_READY) begin
        issues++;
        if (first_issue < 0) first_issue = int'(cyc);
`ifdef IFB_MISALIGN_CHECK_EN
        if (PC_IN[1:0] != 2'b00) begin
          check1("misaligned_not_sent", IMEM_REQ_VALID, 1'b0);
          exp_q.push_back('{pc: PC_IN, ins: NOP, mis: 1'b1});
        end else
`endif
        begin
          mem_q.push_back('{data: next_data, due: cyc + $urandom_range(lat_hi, lat_lo), live: 1'b1});
          exp_q.push_back('{pc: PC_IN, ins: next_data, mis: 1'b0});
          next_data = next_data + 32'h1;
        end
      end
      live = 0;
      foreach (mem_q[i]) if (mem_q[i].live) live++;
      occ = mem_q.size() + exp_q.size() - live;
      check1("occupancy_le_depth", occ <= DEPTH, 1'b1);
      occ_prev = occ;
    end
    cyc++;
    @(negedge CLK);
  endtask

  // Present sequential PCs for n cycles, advancing only on acceptance.
  task automatic run_pcs(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      PC_VALID = 1'b1;
      PC_IN    = pc;
      cycle();
      if (s_pc_ready) pc = pc + 32'h4;
    end
    PC_VALID = 1'b0;
  endtask

  // Empty the pipeline with a bounded cycle budget.
  task automatic drain();
    int unsigned k;
    PC_VALID = 1'b0;
    ID_READY = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && k < 60) begin
      cycle();
      k++;
    end
    check("drain_outstanding", 32'(exp_q.size() + mem_q.size()), 32'h0);
    cycle();
    check1("drained_id_valid", s_id_valid, 1'b0);
  endtask

  initial begin
    int unsigned base_issues, base_ids;
    RST_N = 1'b0; PC_IN = '0; PC_VALID = 1'b0; FLUSH = 1'b0;
    IMEM_REQ_READY = 1'b1; IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = '0;
    ID_READY = 1'b0;
    @(negedge CLK);
    cycle(); cycle(); cycle();
    RST_N = 1'b1;
    cycle();
    check1("reset_id_valid", s_id_valid, 1'b0);
    check("reset_id_pc", s_id_pc, 32'h0);
    check("reset_id_instruction", s_id_ins, NOP);
    check1("reset_id_misaligned", s_id_mis, 1'b0);

    // In-order stream, 1-cycle memory, decode always ready.
    next_data = 32'hA; pc = 32'h0; ID_READY = 1'b1;
    first_issue = -1; first_valid = -1; base_ids = ids_seen; base_issues = issues;
    while (issues - base_issues < 3 && cyc < 200) run_pcs(1);
    drain();
    check("stream_ids", 32'(ids_seen - base_ids), 32'd3);
    check("issue_to_valid_latency", 32'(first_valid - first_issue), 32'd2);

    // Decode stalled: credit caps outstanding work at DEPTH.
    ID_READY = 1'b0; base_issues = issues; base_ids = ids_seen;
    run_pcs(8);
    check("stall_issues", 32'(issues - base_issues), 32'd4);
    check1("stall_pc_ready", s_pc_ready, 1'b0);
    ID_READY = 1'b1;
    run_pcs(12);
    drain();
    check("stall_no_loss", 32'(ids_seen - base_ids), 32'(issues - base_issues));

    // Three fetches in flight, then FLUSH: late responses must vanish.
    lat_lo = 6; lat_hi = 6; base_issues = issues;
    run_pcs(3);
    check("flush_inflight", 32'(issues - base_issues), 32'd3);
    FLUSH = 1'b1; PC_VALID = 1'b1;
    cycle();
    FLUSH = 1'b0; PC_VALID = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      cycle();
      check1("flush_id_quiet", s_id_valid, 1'b0);
    end
    lat_lo = 1; lat_hi = 1; next_data = 32'hD; pc = 32'h100; base_ids = ids_seen;
    run_pcs(1);
    drain();
    check("post_flush_ids", 32'(ids_seen - base_ids), 32'd1);

    // Toggling request ready, 1-3 cycle latency, random decode ready.
    lat_lo = 1; lat_hi = 3; base_issues = issues; base_ids = ids_seen;
    for (int unsigned k = 0; k < 300; k++) begin
      IMEM_REQ_READY = ~IMEM_REQ_READY;
      ID_READY = 1'($urandom_range(1, 0));
      run_pcs(1);
    end
    IMEM_REQ_READY = 1'b1;
    drain();
    check("random_no_loss", 32'(ids_seen - base_ids), 32'(issues - base_issues));

    // Reset with two buffered entries and one fetch still in flight.
    lat_lo = 2; lat_hi = 2; ID_READY = 1'b0;
    run_pcs(3);
    cycle();
    check1("pre_reset_valid", s_id_valid, 1'b1);
    RST_N = 1'b0; PC_VALID = 1'b1; PC_IN = pc;
    cycle();
    RST_N = 1'b1;
    cycle();
    check1("post_reset_id_valid", s_id_valid, 1'b0);
    check("post_reset_instruction", s_id_ins, NOP);
    check("post_reset_id_pc", s_id_pc, 32'h0);
    check1("post_reset_pc_ready", s_pc_ready, 1'b1);
    drain();

`ifdef IFB_MISALIGN_CHECK_EN
    // Misaligned PC becomes a local NOP entry behind the aligned fetch.
    lat_lo = 1; lat_hi = 1; base_ids = ids_seen;
    PC_VALID = 1'b1; PC_IN = 32'h0;
    cycle();
    PC_IN = 32'h6;
    cycle();
    check1("misaligned_accepted", s_pc_ready, 1'b1);
    drain();
    check("misaligned_ids", 32'(ids_seen - base_ids), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
